// File: rtl/store_buffer_if.sv
// Store buffer bus: CPU store/load-lookup side plus the data-memory write port.
// master drives the stores and memory handshake; slave is the buffer itself.
interface store_buffer_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                     we;
  logic [1:0]               st_en;
  logic [ADDRESS_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0]    wd;
  logic [ADDRESS_WIDTH-1:0] ld_addr;
  logic                     mem_ready;
  logic                     stall;
  logic                     misalign;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0]    mem_wd;
  logic [3:0]               mem_be;
  logic                     fwd_hit;
  logic [DATA_WIDTH-1:0]    fwd_data;
  logic [3:0]               fwd_be;
  logic                     empty;
  logic [CW-1:0]            count;

  modport master (
    output we, st_en, alu_result, wd, ld_addr, mem_ready,
    input  stall, misalign, mem_we, mem_a, mem_wd, mem_be,
           fwd_hit, fwd_data, fwd_be, empty, count
  );

  modport slave (
    input  we, st_en, alu_result, wd, ld_addr, mem_ready,
    output stall, misalign, mem_we, mem_a, mem_wd, mem_be,
           fwd_hit, fwd_data, fwd_be, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer between CPU and data memory: lane-aligns stores,
// drains them in order, and forwards buffered bytes to younger loads.
module store_buffer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = ADDRESS_WIDTH - 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  logic [WW-1:0]         ent_wa   [DEPTH];
  logic [3:0]            ent_be   [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]      ent_valid;

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  size_e                 size;
  logic [1:0]            off;
  logic                  illegal;
  logic [3:0]            new_be;
  logic [DATA_WIDTH-1:0] new_data;
  logic                  full, pop, legal, push;

  logic unused_ld_lo;
  assign unused_ld_lo = ^bus.ld_addr[1:0];

  always_comb begin
    size     = size_e'(bus.st_en);
    off      = bus.alu_result[1:0];
    illegal  = 1'b0;
    new_be   = '0;
    new_data = '0;
    case (size)
      SZ_BYTE: begin
        new_be   = 4'b0001 << off;
        new_data = {{(DATA_WIDTH-8){1'b0}}, bus.wd[7:0]} << {off, 3'b000};
      end
      SZ_HALF: begin
        illegal  = off[0];
        new_be   = 4'b0011 << off;
        new_data = {{(DATA_WIDTH-16){1'b0}}, bus.wd[15:0]} << {off, 3'b000};
      end
      SZ_WORD: begin
        illegal  = (off != 2'b00);
        new_be   = 4'b1111;
        new_data = bus.wd;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign full  = (count == CW'(DEPTH));
  assign pop   = bus.mem_we & bus.mem_ready;
  assign legal = bus.we & ~illegal;
  assign push  = legal & (~full | pop);

  assign bus.misalign = bus.we & illegal;
  assign bus.stall    = legal & full & ~pop;
  assign bus.empty    = (count == '0);
  assign bus.count    = count;
  assign bus.mem_we   = ~bus.empty;
  assign bus.mem_a    = {ent_wa[head], 2'b00};
  assign bus.mem_wd   = ent_data[head];
  assign bus.mem_be   = ent_be[head];

  // Pop is applied before push so a full-buffer push/pop (tail==head)
  // leaves the slot valid with the new entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      if (push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_wa[tail]   <= bus.alu_result[ADDRESS_WIDTH-1:2];
      ent_be[tail]   <= new_be;
      ent_data[tail] <= new_data;
    end
  end

  // Scan oldest to youngest so the youngest matching entry owns each lane.
  always_comb begin
    logic [PW-1:0] idx;
    idx          = '0;
    bus.fwd_be   = '0;
    bus.fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (ent_valid[idx] && (ent_wa[idx] == bus.ld_addr[ADDRESS_WIDTH-1:2])) begin
        for (int unsigned l = 0; l < 4; l++) begin
          if (ent_be[idx][l]) begin
            bus.fwd_be[l]           = 1'b1;
            bus.fwd_data[8*l +: 8]  = ent_data[idx][8*l +: 8];
          end
        end
      end
    end
  end

  assign bus.fwd_hit = |bus.fwd_be;

endmodule
